// File: rtl/bcd_share_pkg.sv
// Shared types and constants for the BCD conversion arbiter.
package bcd_share_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Largest operand representable in two BCD digits, and the value
    // substituted for anything larger.
    localparam logic [7:0] BCD_MAX = 8'd99;
    localparam logic [7:0] BCD_SAT = 8'd99;

endpackage

// File: rtl/binbcd.sv
// Combinational binary (0..99) to two-digit BCD converter.
module binbcd (
    input  logic [7:0] bin_i,
    output logic [3:0] bcd1_o,
    output logic [3:0] bcd0_o
);

    logic [3:0] tens;

    // Tens digit by threshold compare, units digit as the remainder.
    always_comb begin
        tens = 4'd0;
        for (int d = 1; d < 10; d++) begin
            if (bin_i >= 8'(d * 10)) tens = 4'(d);
        end
        bcd1_o = tens;
        bcd0_o = 4'(bin_i - 8'(tens) * 8'd10);
    end

endmodule

// File: rtl/bcd_share_arbiter.sv
// Round-robin arbiter sharing one binbcd converter among N_REQ requesters.
// A grant latches the operand and id; the result is registered one cycle
// later and presented with a single-cycle ack/valid pulse.
module bcd_share_arbiter
    import bcd_share_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_i,
    input  logic [8*N_REQ-1:0] bin_i,
    output logic [N_REQ-1:0]   ack_o,
    output logic               valid_o,
    output logic [IDW-1:0]     id_o,
    output logic [3:0]         bcd1_o,
    output logic [3:0]         bcd0_o,
    output logic               ovf_o,
    output logic               busy_o
);

    state_t               state_q, state_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [N_REQ-1:0]     mask_q, mask_d;
    logic [7:0]           opnd_q, opnd_d;
    logic [IDW-1:0]       gid_q, gid_d;
    logic [IDW-1:0]       rid_q, rid_d;
    logic [3:0]           bcd1_q, bcd1_d;
    logic [3:0]           bcd0_q, bcd0_d;
    logic                 ovf_q, ovf_d;

    logic [N_REQ-1:0]     req_avail;
    logic [IDW-1:0]       pick;
    logic [7:0]           sat_opnd;
    logic [3:0]           conv_tens, conv_units;

    // First set bit at or after ptr, wrapping past N_REQ-1 back to 0.
    function automatic logic [IDW-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDW-1:0]   ptr);
        logic [IDW-1:0] sel;
        logic           found;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            int j;
            j = (int'(ptr) + i) % N_REQ;
            if (!found && req[j]) begin
                found = 1'b1;
                sel   = IDW'(j);
            end
        end
        return sel;
    endfunction

    // Clamp operands the converter cannot represent.
    function automatic logic [7:0] sat_bin(input logic [7:0] b);
        return (b > BCD_MAX) ? BCD_SAT : b;
    endfunction

    assign req_avail = req_i & ~mask_q;
    assign pick      = rr_pick(req_avail, ptr_q);
    assign sat_opnd  = sat_bin(opnd_q);

    binbcd u_binbcd (
        .bin_i  (sat_opnd),
        .bcd1_o (conv_tens),
        .bcd0_o (conv_units)
    );

    // State register; reset aborts any conversion in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: grant, one convert cycle, one result cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req_avail) state_d = CONVERT;
            CONVERT: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are driven only while the result is presented.
    always_comb begin
        valid_o = (state_q == DONE);
        ack_o   = valid_o ? ({{(N_REQ-1){1'b0}}, 1'b1} << gid_q) : '0;
        busy_o  = (state_q != IDLE);
    end

    // Datapath next values: latch on grant, capture result, advance pointer.
    always_comb begin
        ptr_d  = ptr_q;
        mask_d = mask_q;
        opnd_d = opnd_q;
        gid_d  = gid_q;
        rid_d  = rid_q;
        bcd1_d = bcd1_q;
        bcd0_d = bcd0_q;
        ovf_d  = ovf_q;
        case (state_q)
            IDLE: begin
                // The served mask only shadows the first IDLE cycle.
                mask_d = '0;
                if (|req_avail) begin
                    gid_d  = pick;
                    opnd_d = bin_i[{pick, 3'b000} +: 8];
                end
            end
            CONVERT: begin
                rid_d  = gid_q;
                bcd1_d = conv_tens;
                bcd0_d = conv_units;
                ovf_d  = (opnd_q > BCD_MAX);
            end
            DONE: begin
                ptr_d  = (gid_q == IDW'(N_REQ - 1)) ? '0 : gid_q + IDW'(1);
                mask_d = {{(N_REQ-1){1'b0}}, 1'b1} << gid_q;
            end
            default: ;
        endcase
    end

    // Datapath and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q  <= '0;
            mask_q <= '0;
            opnd_q <= '0;
            gid_q  <= '0;
            rid_q  <= '0;
            bcd1_q <= '0;
            bcd0_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            mask_q <= mask_d;
            opnd_q <= opnd_d;
            gid_q  <= gid_d;
            rid_q  <= rid_d;
            bcd1_q <= bcd1_d;
            bcd0_q <= bcd0_d;
            ovf_q  <= ovf_d;
        end
    end

    assign id_o   = rid_q;
    assign bcd1_o = bcd1_q;
    assign bcd0_o = bcd0_q;
    assign ovf_o  = ovf_q;

endmodule
